// File: rtl/cmpl_pkg.sv
// Shared types for the dual-rail completion monitor: FSM states, rail pair, link encodings.
package cmpl_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_DATA   = 2'd0,
    ST_HOLD        = 2'd1,
    ST_WAIT_SPACER = 2'd2,
    ST_ERR         = 2'd3
  } state_t;

  // Rail pair: [1] = rail1 (logic 1), [0] = rail0 (logic 0).
  typedef logic [1:0] dr_t;

  localparam string ENC_TP = "TP";
  localparam string ENC_FP = "FP";

endpackage

// File: rtl/cmpl_mon_ch.sv
// One channel: completion detect, word hold until out_ready, ack generation, error/timeout.
// Word appears one cycle after a complete codeword in i_s; held while out_ready is low.
module cmpl_mon_ch
  import cmpl_pkg::*;
#(
  parameter string ENC     = "TP",
  parameter int    WIDTH   = 1,
  parameter int    TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  dr_t [WIDTH-1:0]  i_s,
  input  logic             i_out_ready,
  input  logic             i_err_clr,
  output logic             o_ack,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_err
);

  localparam bit IS_FP = (ENC == ENC_FP);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  state_t           r_state, w_state;
  dr_t [WIDTH-1:0]  r_ref, w_ref, w_code;
  logic [WIDTH-1:0] r_data, w_data, w_ok, w_bad, w_zero, w_tgt;
  logic             r_ack, w_ack;
  logic [CW-1:0]    r_cnt, w_cnt;
  logic             w_partial, w_tout;

  // In TP the codeword is the set of rails that moved since the last accepted word.
  always_comb begin
    w_code = IS_FP ? i_s : (i_s ^ r_ref);
    w_ok   = '0;
    w_bad  = '0;
    w_zero = '0;
    for (int b = 0; b < WIDTH; b++) begin
      w_ok[b]   = ^w_code[b];
      w_bad[b]  = &w_code[b];
      w_zero[b] = ~|i_s[b];
    end
    w_tgt     = (r_state == ST_WAIT_SPACER) ? w_zero : w_ok;
    w_partial = (|w_tgt) && !(&w_tgt);
    w_tout    = (TIMEOUT > 0) && w_partial && (r_cnt == CNT_LAST);
  end

  always_comb begin
    w_state = r_state;
    w_ref   = r_ref;
    w_data  = r_data;
    w_ack   = r_ack;
    w_cnt   = '0;
    unique case (r_state)
      ST_WAIT_DATA: begin
        if ((|w_bad) || w_tout) begin
          w_state = ST_ERR;
        end else if (&w_ok) begin
          for (int b = 0; b < WIDTH; b++) w_data[b] = w_code[b][1];
          w_state = ST_HOLD;
        end else if (w_partial && (TIMEOUT > 0)) begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      ST_HOLD: begin
        if (i_out_ready) begin
          if (IS_FP) begin
            w_ack   = 1'b1;
            w_state = ST_WAIT_SPACER;
          end else begin
            w_ack = ~r_ack;
            for (int b = 0; b < WIDTH; b++) w_ref[b] = r_ref[b] ^ (r_data[b] ? 2'b10 : 2'b01);
            w_state = ST_WAIT_DATA;
          end
        end
      end
      ST_WAIT_SPACER: begin
        if ((|w_bad) || w_tout) begin
          w_state = ST_ERR;
        end else if (&w_zero) begin
          w_ack   = 1'b0;
          w_state = ST_WAIT_DATA;
        end else if (w_partial && (TIMEOUT > 0)) begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      ST_ERR: begin
        // Recovery resynchronises to the current line state instead of the lost history.
        if (i_err_clr) begin
          if (IS_FP) begin
            w_ack   = 1'b0;
            w_state = ST_WAIT_SPACER;
          end else begin
            w_ref   = i_s;
            w_state = ST_WAIT_DATA;
          end
        end
      end
      default: w_state = ST_WAIT_DATA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_WAIT_DATA;
      r_ref   <= '0;
      r_data  <= '0;
      r_ack   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_ref   <= w_ref;
      r_data  <= w_data;
      r_ack   <= w_ack;
      r_cnt   <= w_cnt;
    end
  end

  assign o_ack   = r_ack;
  assign o_data  = r_data;
  assign o_valid = (r_state == ST_HOLD);
  assign o_err   = (r_state == ST_ERR);

endmodule

// File: rtl/cmpl_mon.sv
// Dual-rail completion monitor: per-rail synchronisers feeding CH independent channels.
// Latency SYNC_STAGES+1 edges from a stable codeword; each channel holds its word until out_ready.
module cmpl_mon
  import cmpl_pkg::*;
#(
  parameter string ENC         = "TP",
  parameter int    WIDTH       = 1,
  parameter int    CH          = 1,
  parameter int    SYNC_STAGES = 2,
  parameter int    TIMEOUT     = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  dr_t [CH-1:0][WIDTH-1:0]  in,
  output logic [CH-1:0]            ack,
  output logic [CH-1:0][WIDTH-1:0] out_data,
  output logic [CH-1:0]            out_valid,
  input  logic [CH-1:0]            out_ready,
  output logic [CH-1:0]            err,
  input  logic [CH-1:0]            err_clr
);

  localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  dr_t [CH-1:0][WIDTH-1:0] r_sync [NS];
  dr_t [CH-1:0][WIDTH-1:0] w_s;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NS; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= in;
      for (int i = 1; i < NS; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_s = r_sync[NS-1];

  for (genvar c = 0; c < CH; c++) begin : g_ch
    cmpl_mon_ch #(
      .ENC     (ENC),
      .WIDTH   (WIDTH),
      .TIMEOUT (TIMEOUT)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .i_s         (w_s[c]),
      .i_out_ready (out_ready[c]),
      .i_err_clr   (err_clr[c]),
      .o_ack       (ack[c]),
      .o_data      (out_data[c]),
      .o_valid     (out_valid[c]),
      .o_err       (err[c])
    );
  end

endmodule

// File: tb/tb_cmpl_mon.sv
// Directed bench: FP (no timeout), FP (TIMEOUT=8) and TP monitors, WIDTH=4, CH=2, SYNC_STAGES=2.
module tb_cmpl_mon;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0][3:0][1:0] fp_in, fpt_in, tp_in;
  logic [1:0][3:0]      fp_data, fpt_data, tp_data;
  logic [1:0]           fp_ack, fp_valid, fp_ready, fp_err, fp_clr;
  logic [1:0]           fpt_ack, fpt_valid, fpt_ready, fpt_err, fpt_clr;
  logic [1:0]           tp_ack, tp_valid, tp_ready, tp_err, tp_clr;

  int n_chk  = 0;
  int n_pass = 0;

  cmpl_mon #(.ENC("FP"), .WIDTH(4), .CH(2), .SYNC_STAGES(2), .TIMEOUT(0)) u_fp (
    .clk(clk), .rst(rst), .in(fp_in), .ack(fp_ack), .out_data(fp_data),
    .out_valid(fp_valid), .out_ready(fp_ready), .err(fp_err), .err_clr(fp_clr));

  cmpl_mon #(.ENC("FP"), .WIDTH(4), .CH(2), .SYNC_STAGES(2), .TIMEOUT(8)) u_fpt (
    .clk(clk), .rst(rst), .in(fpt_in), .ack(fpt_ack), .out_data(fpt_data),
    .out_valid(fpt_valid), .out_ready(fpt_ready), .err(fpt_err), .err_clr(fpt_clr));

  cmpl_mon #(.ENC("TP"), .WIDTH(4), .CH(2), .SYNC_STAGES(2), .TIMEOUT(0)) u_tp (
    .clk(clk), .rst(rst), .in(tp_in), .ack(tp_ack), .out_data(tp_data),
    .out_valid(tp_valid), .out_ready(tp_ready), .err(tp_err), .err_clr(tp_clr));

  // Dual-rail codeword for a 4-bit value: 1 -> 10, 0 -> 01 (also the TP toggle mask).
  function automatic logic [3:0][1:0] code4(input logic [3:0] d);
    logic [3:0][1:0] r;
    for (int b = 0; b < 4; b++) r[b] = d[b] ? 2'b10 : 2'b01;
    return r;
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick(2);
    n_chk++; if (fp_valid !== 2'b00) $display("FAIL rst_fp_valid: got %b want 00", fp_valid); else n_pass++;
    n_chk++; if (fp_ack !== 2'b00) $display("FAIL rst_fp_ack: got %b want 00", fp_ack); else n_pass++;
    n_chk++; if (fp_err !== 2'b00) $display("FAIL rst_fp_err: got %b want 00", fp_err); else n_pass++;
    n_chk++; if (fp_data !== 8'h00) $display("FAIL rst_fp_data: got %h want 00", fp_data); else n_pass++;
    n_chk++; if (tp_ack !== 2'b00 || tp_valid !== 2'b00) $display("FAIL rst_tp: got ack %b valid %b want 00 00", tp_ack, tp_valid); else n_pass++;
    n_chk++; if (fpt_err !== 2'b00) $display("FAIL rst_fpt_err: got %b want 00", fpt_err); else n_pass++;
    rst = 1'b1;
    tick(1);
  endtask

  task automatic test_fp_complete;
    fp_in[0] = code4(4'b1010);
    tick(2);
    n_chk++; if (fp_valid[0] !== 1'b0) $display("FAIL fp_early_valid: got %b want 0", fp_valid[0]); else n_pass++;
    tick(1);
    n_chk++; if (fp_valid[0] !== 1'b1) $display("FAIL fp_valid_edge3: got %b want 1", fp_valid[0]); else n_pass++;
    n_chk++; if (fp_data[0] !== 4'b1010) $display("FAIL fp_data: got %b want 1010", fp_data[0]); else n_pass++;
    n_chk++; if (fp_ack[0] !== 1'b0) $display("FAIL fp_ack_hold: got %b want 0", fp_ack[0]); else n_pass++;
    tick(1);
    n_chk++; if (fp_ack[0] !== 1'b1) $display("FAIL fp_ack_rise: got %b want 1", fp_ack[0]); else n_pass++;
    n_chk++; if (fp_valid[0] !== 1'b0) $display("FAIL fp_valid_drop: got %b want 0", fp_valid[0]); else n_pass++;
    fp_in[0] = '0;
    tick(2);
    n_chk++; if (fp_ack[0] !== 1'b1) $display("FAIL fp_ack_spacer_early: got %b want 1", fp_ack[0]); else n_pass++;
    tick(1);
    n_chk++; if (fp_ack[0] !== 1'b0) $display("FAIL fp_ack_fall: got %b want 0", fp_ack[0]); else n_pass++;
  endtask

  task automatic test_tp_toggle;
    tp_in[0] = tp_in[0] ^ code4(4'h5);
    tick(3);
    n_chk++; if (tp_valid[0] !== 1'b1 || tp_data[0] !== 4'h5) $display("FAIL tp_word1: got valid %b data %h want 1 5", tp_valid[0], tp_data[0]); else n_pass++;
    tick(1);
    n_chk++; if (tp_ack[0] !== 1'b1 || tp_valid[0] !== 1'b0) $display("FAIL tp_ack1: got ack %b valid %b want 1 0", tp_ack[0], tp_valid[0]); else n_pass++;
    tp_in[0] = tp_in[0] ^ code4(4'hC);
    tick(3);
    n_chk++; if (tp_valid[0] !== 1'b1 || tp_data[0] !== 4'hC) $display("FAIL tp_word2: got valid %b data %h want 1 c", tp_valid[0], tp_data[0]); else n_pass++;
    tick(1);
    n_chk++; if (tp_ack[0] !== 1'b0) $display("FAIL tp_ack2: got %b want 0", tp_ack[0]); else n_pass++;
    // A third word decodes correctly only if ref tracked both earlier toggle sets.
    tp_in[0] = tp_in[0] ^ code4(4'h9);
    tick(3);
    n_chk++; if (tp_valid[0] !== 1'b1 || tp_data[0] !== 4'h9) $display("FAIL tp_word3: got valid %b data %h want 1 9", tp_valid[0], tp_data[0]); else n_pass++;
    n_chk++; if (tp_err[0] !== 1'b0) $display("FAIL tp_err: got %b want 0", tp_err[0]); else n_pass++;
    tick(1);
    n_chk++; if (tp_ack[0] !== 1'b1) $display("FAIL tp_ack3: got %b want 1", tp_ack[0]); else n_pass++;
  endtask

  task automatic test_fp_error;
    logic seen_v;
    seen_v = 1'b0;
    fp_in[0] = code4(4'b1010);
    fp_in[0][2] = 2'b11;
    fp_in[1] = code4(4'h3);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (fp_valid[0]) seen_v = 1'b1;
    end
    n_chk++; if (fp_err[0] !== 1'b1) $display("FAIL err_set: got %b want 1", fp_err[0]); else n_pass++;
    n_chk++; if (fp_valid[1] !== 1'b1 || fp_data[1] !== 4'h3) $display("FAIL ch1_word: got valid %b data %h want 1 3", fp_valid[1], fp_data[1]); else n_pass++;
    tick(1);
    if (fp_valid[0]) seen_v = 1'b1;
    n_chk++; if (fp_ack[1] !== 1'b1) $display("FAIL ch1_ack: got %b want 1", fp_ack[1]); else n_pass++;
    fp_in = '0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (fp_valid[0]) seen_v = 1'b1;
    end
    n_chk++; if (fp_err[0] !== 1'b1) $display("FAIL err_sticky: got %b want 1", fp_err[0]); else n_pass++;
    n_chk++; if (fp_ack[1] !== 1'b0) $display("FAIL ch1_ack_fall: got %b want 0", fp_ack[1]); else n_pass++;
    n_chk++; if (seen_v !== 1'b0) $display("FAIL err_ch_valid: got %b want 0", seen_v); else n_pass++;
    fp_clr[0] = 1'b1;
    tick(1);
    fp_clr[0] = 1'b0;
    n_chk++; if (fp_err[0] !== 1'b0 || fp_ack[0] !== 1'b0) $display("FAIL err_clr: got err %b ack %b want 0 0", fp_err[0], fp_ack[0]); else n_pass++;
    tick(1);
    n_chk++; if (fp_err[0] !== 1'b0) $display("FAIL err_stays_clear: got %b want 0", fp_err[0]); else n_pass++;
  endtask

  task automatic test_timeout;
    logic seen_e;
    fpt_in[0] = code4(4'b1010);
    fpt_in[0][3] = 2'b00;
    tick(9);
    n_chk++; if (fpt_err[0] !== 1'b0) $display("FAIL tout_early: got %b want 0", fpt_err[0]); else n_pass++;
    tick(1);
    n_chk++; if (fpt_err[0] !== 1'b1) $display("FAIL tout_fire: got %b want 1", fpt_err[0]); else n_pass++;
    fpt_in[0] = '0;
    tick(3);
    fpt_clr[0] = 1'b1;
    tick(1);
    fpt_clr[0] = 1'b0;
    n_chk++; if (fpt_err[0] !== 1'b0) $display("FAIL tout_clr: got %b want 0", fpt_err[0]); else n_pass++;
    tick(1);
    seen_e = 1'b0;
    fpt_in[0] = code4(4'b1010);
    fpt_in[0][3] = 2'b00;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (fpt_err[0]) seen_e = 1'b1;
    end
    fpt_in[0] = code4(4'b1010);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (fpt_err[0]) seen_e = 1'b1;
    end
    n_chk++; if (fpt_valid[0] !== 1'b1 || fpt_data[0] !== 4'b1010) $display("FAIL tout_late_word: got valid %b data %b want 1 1010", fpt_valid[0], fpt_data[0]); else n_pass++;
    tick(1);
    fpt_in[0] = '0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (fpt_err[0]) seen_e = 1'b1;
    end
    n_chk++; if (seen_e !== 1'b0) $display("FAIL tout_no_err: got %b want 0", seen_e); else n_pass++;
    n_chk++; if (fpt_ack[0] !== 1'b0) $display("FAIL tout_ack_back: got %b want 0", fpt_ack[0]); else n_pass++;
  endtask

  task automatic test_backpressure_reset;
    fp_ready[0] = 1'b0;
    tp_ready[0] = 1'b0;
    fp_in[0] = code4(4'b0110);
    fp_in[1] = '0;
    fp_in[1][0] = 2'b11;
    tp_in[0] = tp_in[0] ^ code4(4'h6);
    tick(3);
    n_chk++; if (fp_valid[0] !== 1'b1 || fp_data[0] !== 4'b0110) $display("FAIL bp_fp_word: got valid %b data %b want 1 0110", fp_valid[0], fp_data[0]); else n_pass++;
    n_chk++; if (tp_valid[0] !== 1'b1 || tp_data[0] !== 4'h6 || tp_ack[0] !== 1'b1) $display("FAIL bp_tp_word: got valid %b data %h ack %b want 1 6 1", tp_valid[0], tp_data[0], tp_ack[0]); else n_pass++;
    n_chk++; if (fp_err[1] !== 1'b1) $display("FAIL bp_ch1_err: got %b want 1", fp_err[1]); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      fp_clr[0] = (i == 0);
      tick(1);
      n_chk++; if (fp_valid[0] !== 1'b1 || fp_data[0] !== 4'b0110 || fp_ack[0] !== 1'b0) $display("FAIL bp_fp_hold%0d: got valid %b data %b ack %b want 1 0110 0", i, fp_valid[0], fp_data[0], fp_ack[0]); else n_pass++;
      n_chk++; if (tp_valid[0] !== 1'b1 || tp_data[0] !== 4'h6 || tp_ack[0] !== 1'b1) $display("FAIL bp_tp_hold%0d: got valid %b data %h ack %b want 1 6 1", i, tp_valid[0], tp_data[0], tp_ack[0]); else n_pass++;
    end
    fp_clr[0] = 1'b0;
    rst = 1'b0;
    fp_in = '0;
    tp_in = '0;
    tick(1);
    n_chk++; if (fp_valid !== 2'b00 || fp_ack !== 2'b00 || fp_err !== 2'b00) $display("FAIL mid_rst_fp: got valid %b ack %b err %b want 00 00 00", fp_valid, fp_ack, fp_err); else n_pass++;
    n_chk++; if (tp_valid[0] !== 1'b0 || tp_ack[0] !== 1'b0) $display("FAIL mid_rst_tp: got valid %b ack %b want 0 0", tp_valid[0], tp_ack[0]); else n_pass++;
    rst = 1'b1;
    fp_ready = 2'b11;
    tp_ready = 2'b11;
    tick(1);
  endtask

  task automatic test_after_reset;
    fp_in[0] = code4(4'b1100);
    tp_in[0] = code4(4'h3);
    tick(3);
    n_chk++; if (fp_valid[0] !== 1'b1 || fp_data[0] !== 4'b1100) $display("FAIL post_rst_fp: got valid %b data %b want 1 1100", fp_valid[0], fp_data[0]); else n_pass++;
    n_chk++; if (tp_valid[0] !== 1'b1 || tp_data[0] !== 4'h3) $display("FAIL post_rst_tp: got valid %b data %h want 1 3", tp_valid[0], tp_data[0]); else n_pass++;
    tick(1);
    n_chk++; if (fp_ack[0] !== 1'b1 || tp_ack[0] !== 1'b1) $display("FAIL post_rst_ack: got fp %b tp %b want 1 1", fp_ack[0], tp_ack[0]); else n_pass++;
  endtask

  initial begin
    rst = 1'b0;
    fp_in = '0;  fpt_in = '0;  tp_in = '0;
    fp_ready = 2'b11; fpt_ready = 2'b11; tp_ready = 2'b11;
    fp_clr = '0; fpt_clr = '0; tp_clr = '0;
    test_reset();
    test_fp_complete();
    test_tp_toggle();
    test_fp_error();
    test_timeout();
    test_backpressure_reset();
    test_after_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
